// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int unsigned REG_WIDTH      = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned CNT_WIDTH_DEF  = 16;

   typedef logic [1:0] gnt_t;

   localparam gnt_t GNT_NONE = 2'b00;
   localparam gnt_t GNT_A    = 2'b01;
   localparam gnt_t GNT_B    = 2'b10;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// One writeback requester channel: valid/index/data toward the arbiter, ready back.
interface regfile_wb_arbiter_if #(
   parameter int unsigned REG_WIDTH      = regfile_wb_arbiter_pkg::REG_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = regfile_wb_arbiter_pkg::REG_ADDR_WIDTH
);

   logic                      Valid;
   logic [REG_ADDR_WIDTH-1:0] Rd;
   logic [REG_WIDTH-1:0]      Data;
   logic                      Ready;

   modport master (output Valid, Rd, Data, input Ready);
   modport slave  (input Valid, Rd, Data, output Ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; the last winner loses the next conflict.
module rr_arbiter2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic Clk_i,
   input  logic Rst_i,
   input  logic a_valid,
   input  logic b_valid,
   output gnt_t gnt_c
);

   gnt_t last_grant;

   // Grant is held off entirely while reset is high so nothing is accepted.
   always_comb begin
      gnt_c = GNT_NONE;
      if (!Rst_i) begin
         if (a_valid && b_valid) begin
            gnt_c = (last_grant == GNT_B) ? GNT_A : GNT_B;
         end else if (a_valid) begin
            gnt_c = GNT_A;
         end else if (b_valid) begin
            gnt_c = GNT_B;
         end
      end
   end

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         last_grant <= GNT_B;
      end else if (gnt_c != GNT_NONE) begin
         last_grant <= gnt_c;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between two writeback requesters,
// with a one-cycle write stage, read bypass flags and a conflict counter.
module regfile_wb_arbiter #(
   parameter int unsigned REG_WIDTH      = regfile_wb_arbiter_pkg::REG_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = regfile_wb_arbiter_pkg::REG_ADDR_WIDTH,
   parameter bit          R0_IS_ZERO     = 1'b1,
   parameter int unsigned CNT_WIDTH      = regfile_wb_arbiter_pkg::CNT_WIDTH_DEF
) (
   input  logic                      Clk_i,
   input  logic                      Rst_i,
   regfile_wb_arbiter_if.slave       A,
   regfile_wb_arbiter_if.slave       B,
   output logic                      Wb_We_o,
   output logic [REG_ADDR_WIDTH-1:0] Wb_Rd_o,
   output logic [REG_WIDTH-1:0]      Wb_Data_o,
   input  logic [REG_ADDR_WIDTH-1:0] Ra_Sel_i,
   input  logic [REG_ADDR_WIDTH-1:0] Rb_Sel_i,
   output logic                      Ra_Fwd_o,
   output logic                      Rb_Fwd_o,
   output logic [CNT_WIDTH-1:0]      Conflict_Cnt_o
);

   regfile_wb_arbiter_pkg::gnt_t gnt_c;
   logic                         accept_c;
   logic                         issue_c;
   logic [REG_ADDR_WIDTH-1:0]    win_rd_c;
   logic [REG_WIDTH-1:0]         win_data_c;

   rr_arbiter2 u_arb (
      .Clk_i   (Clk_i),
      .Rst_i   (Rst_i),
      .a_valid (A.Valid),
      .b_valid (B.Valid),
      .gnt_c   (gnt_c)
   );

   assign A.Ready = (gnt_c == regfile_wb_arbiter_pkg::GNT_A);
   assign B.Ready = (gnt_c == regfile_wb_arbiter_pkg::GNT_B);

   // Winner payload mux; a grant always implies the winner is valid.
   always_comb begin
      win_rd_c   = '0;
      win_data_c = '0;
      accept_c   = 1'b0;
      case (gnt_c)
         regfile_wb_arbiter_pkg::GNT_A: begin
            win_rd_c   = A.Rd;
            win_data_c = A.Data;
            accept_c   = 1'b1;
         end
         regfile_wb_arbiter_pkg::GNT_B: begin
            win_rd_c   = B.Rd;
            win_data_c = B.Data;
            accept_c   = 1'b1;
         end
         default: ;
      endcase
   end

   // Writes to r0 are acknowledged but never reach the register file.
   assign issue_c = accept_c && !(R0_IS_ZERO && (win_rd_c == '0));

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         Wb_We_o   <= 1'b0;
         Wb_Rd_o   <= '0;
         Wb_Data_o <= '0;
      end else if (accept_c) begin
         Wb_We_o   <= issue_c;
         Wb_Rd_o   <= win_rd_c;
         Wb_Data_o <= win_data_c;
      end else begin
         Wb_We_o   <= 1'b0;
      end
   end

   assign Ra_Fwd_o = Wb_We_o && (Wb_Rd_o == Ra_Sel_i) && !(R0_IS_ZERO && (Ra_Sel_i == '0));
   assign Rb_Fwd_o = Wb_We_o && (Wb_Rd_o == Rb_Sel_i) && !(R0_IS_ZERO && (Rb_Sel_i == '0));

   // Saturating count of cycles where both requesters competed.
   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         Conflict_Cnt_o <= '0;
      end else if (A.Valid && B.Valid && (Conflict_Cnt_o != '1)) begin
         Conflict_Cnt_o <= Conflict_Cnt_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single synchronous write port of the core register file between two writeback requesters. Requester A is the execute/ALU path; requester B is the load/CSR path. Uses round-robin arbitration, a registered write stage with 1-cycle latency, and read-port bypass flags so async readers see data that is in flight. Sits between the writeback sources and the register file write port (Data_We/Rd_Sel/Data).

Parameters:
REG_WIDTH, 32, data width of a register.
REG_ADDR_WIDTH, 5, register index width.
R0_IS_ZERO, 1, when 1, writes to index 0 are accepted but never issued, and index 0 never bypasses.
CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
Clk_i  in  1  clock; all state updates on the rising edge.
Rst_i  in  1  synchronous, active-high reset.
A_Valid_i  in  1  requester A has a write.
A_Rd_i  in  REG_ADDR_WIDTH  requester A destination index.
A_Data_i  in  REG_WIDTH  requester A write data.
A_Ready_o  out  1  requester A accepted this cycle.
B_Valid_i  in  1  requester B has a write.
B_Rd_i  in  REG_ADDR_WIDTH  requester B destination index.
B_Data_i  in  REG_WIDTH  requester B write data.
B_Ready_o  out  1  requester B accepted this cycle.
Wb_We_o  out  1  to register file Data_We.
Wb_Rd_o  out  REG_ADDR_WIDTH  to register file Rd_Sel.
Wb_Data_o  out  REG_WIDTH  to register file Data.
Ra_Sel_i  in  REG_ADDR_WIDTH  copy of read port 1 select.
Rb_Sel_i  in  REG_ADDR_WIDTH  copy of read port 2 select.
Ra_Fwd_o  out  1  read port 1 must use Wb_Data_o instead of the register file output.
Rb_Fwd_o  out  1  read port 2 must use Wb_Data_o instead of the register file output.
Conflict_Cnt_o  out  CNT_WIDTH  number of cycles in which both requesters were valid.

Behaviour:
- Reset (Rst_i=1 at an edge):
  - Wb_We_o=0, Wb_Rd_o=0, Wb_Data_o=0.
  - last_grant=B, so A wins the first conflict.
  - Conflict_Cnt_o=0.
  - A_Ready_o and B_Ready_o are forced to 0 while Rst_i is high. A request presented during reset is not accepted and must be held.
  - Reset mid-operation discards the staged write (Wb_We_o=0 the next cycle).
- Grant (combinational from valids and last_grant; no dependency on any downstream ready):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- A_Ready_o=grant_A and B_Ready_o=grant_B. They are never both 1.
- Accept = Valid & Ready. An ungranted requester must hold its Valid/Rd/Data stable until it is accepted.
- Pointer update: last_grant updates only on an accept. An idle cycle preserves it.
- Write stage:
  - On an accept at edge N, Wb_We_o=1 with Wb_Rd_o/Wb_Data_o taken from the winner, visible in the cycle after edge N. The register file commits at edge N+1.
  - Latency is 1 cycle. Throughput is 1 write per cycle.
  - With no accept, Wb_We_o=0 and Wb_Rd_o/Wb_Data_o hold their previous values.
- R0 handling: if R0_IS_ZERO=1 and the accepted Rd is 0, the requester is still acknowledged and the pointer still updates, but Wb_We_o=0 the next cycle.
- Bypass (combinational):
  - Ra_Fwd_o = Wb_We_o & (Wb_Rd_o==Ra_Sel_i) & !(R0_IS_ZERO & Ra_Sel_i==0). Rb_Fwd_o is defined the same way.
  - Both flags may be high at once.
- Conflict counter: increments on each cycle with A_Valid_i & B_Valid_i & !Rst_i. It saturates at all-ones with no wrap.
- Same-Rd back-to-back writes are not merged. Both are issued in grant order, and the last one issued wins in the register file.

Decomposition:
- Shared package: grant encoding constants GNT_NONE=2'b00, GNT_A=2'b01, GNT_B=2'b10, and the default widths REG_WIDTH=32, REG_ADDR_WIDTH=5.
- Natural sub-module: rr_arbiter2 (2-input round-robin grant plus last_grant register, synchronous reset). The write stage, bypass compare and counter stay in the top level.

Test Plan:
- Reset then A only (A_Rd=5, A_Data=0xDEADBEEF): A_Ready_o=1 in the same cycle; next cycle Wb_We_o=1, Wb_Rd_o=5, Wb_Data_o=0xDEADBEEF, then Wb_We_o=0.
- A and B both valid and held for 4 cycles (A_Rd=1, B_Rd=2, new data each accept): grants go A,B,A,B; Wb_Rd_o is 1,2,1,2 with 1-cycle lag; Conflict_Cnt_o=4.
- A_Rd=0 with R0_IS_ZERO=1: A_Ready_o=1, Wb_We_o stays 0; Ra_Sel_i=0 gives Ra_Fwd_o=0; a following conflict grants B.
- Staged write to Rd=7 with Ra_Sel_i=7 and Rb_Sel_i=7: Ra_Fwd_o=Rb_Fwd_o=1 for exactly that cycle; Ra_Sel_i=8 gives 0.
- Rst_i asserted in the cycle after an accept: Wb_We_o=0 next cycle, both Readys stay 0 while reset is high, Conflict_Cnt_o=0, and the first post-reset conflict grants A.
- CNT_WIDTH=2 with 5 conflict cycles: Conflict_Cnt_o goes 1,2,3,3,3.
